// File: rtl/cond_exec_stage_pkg.sv
// Shared constants for conditional-execute logic: ARM condition codes and
// flag bit positions within the packed {Z,C,N,V} flag nibble.
package cond_exec_stage_pkg;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] FLAGS_RST = 4'b0000;

endpackage

// File: rtl/cond_eval.sv
// Purpose: decode one ARM condition field against a {Z,C,N,V} flag nibble.
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
module cond_eval
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, c, n, v;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = ~z;
            CC_CS: pass = c;
            CC_CC: pass = ~c;
            CC_MI: pass = n;
            CC_PL: pass = ~n;
            CC_VS: pass = v;
            CC_VC: pass = ~v;
            CC_HI: pass = c & ~z;
            CC_LS: pass = ~c | z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = ~z & (n == v);
            CC_LE: pass = z | (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Purpose: evaluate a bundle of LANES conditional instructions, forward flags in-bundle, keep the flag register.
// Latency: one cycle from in_* to out_valid/out_pass; status visible the cycle after its writing edge.
// Backpressure: stall freezes all state and outputs; flush empties the stage and wins over stall.
module cond_exec_stage
    import cond_exec_stage_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int FWD_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [LANES-1:0]   in_valid,
    input  logic [4*LANES-1:0] in_cond,
    input  logic [LANES-1:0]   in_s,
    input  logic [4*LANES-1:0] in_flags,
    output logic [LANES-1:0]   out_valid,
    output logic [LANES-1:0]   out_pass,
    output logic [3:0]         status
);

    logic [LANES-1:0] pass_vec;
    logic [3:0]       status_nxt;

    // Per-lane signals live inside the generate scope so each lane's chain
    // link is its own net rather than one bit of a self-referencing vector.
    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        logic [3:0] lane_flags;
        logic [3:0] eff;
        logic       pass;
        logic       wr;
        logic [3:0] st_nxt;

        assign lane_flags = in_flags[4*i +: 4];

        if (i == 0 || FWD_EN == 0) begin : g_reg
            assign eff = status;
        end else begin : g_fwd
            assign eff = g_lane[i-1].wr ? g_lane[i-1].lane_flags : g_lane[i-1].eff;
        end

        cond_eval u_eval (
            .cond  (in_cond[4*i +: 4]),
            .flags (eff),
            .pass  (pass)
        );

        assign wr          = in_valid[i] & pass & in_s[i];
        assign pass_vec[i] = pass;

        // Younger writers overwrite older ones as the chain walks up the lanes.
        if (i == 0) begin : g_st0
            assign st_nxt = wr ? lane_flags : status;
        end else begin : g_stn
            assign st_nxt = wr ? lane_flags : g_lane[i-1].st_nxt;
        end
    end

    assign status_nxt = g_lane[LANES-1].st_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status    <= FLAGS_RST;
            out_valid <= '0;
            out_pass  <= '0;
        end else if (flush) begin
            out_valid <= '0;
            out_pass  <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_pass  <= in_valid & pass_vec;
            status    <= status_nxt;
        end
    end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Scoreboarded bench: one forwarding and one non-forwarding instance share stimulus;
// the driver queues expected outputs, a negedge monitor pops and compares.
module tb_cond_exec_stage;

    localparam logic [3:0] EQ = 4'h0;
    localparam logic [3:0] NE = 4'h1;
    localparam logic [3:0] AL = 4'hE;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] p;
        logic [3:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] in_valid = '0;
    logic [7:0] in_cond = '0;
    logic [1:0] in_s = '0;
    logic [7:0] in_flags = '0;

    logic [1:0] f_valid, f_pass, n_valid, n_pass;
    logic [3:0] f_status, n_status;

    int errors = 0;
    int checks = 0;

    exp_t q_f[$];
    exp_t q_n[$];

    always #5 clk = ~clk;

    cond_exec_stage #(.LANES(2), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_cond(in_cond), .in_s(in_s), .in_flags(in_flags),
        .out_valid(f_valid), .out_pass(f_pass), .status(f_status)
    );

    cond_exec_stage #(.LANES(2), .FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_cond(in_cond), .in_s(in_s), .in_flags(in_flags),
        .out_valid(n_valid), .out_pass(n_pass), .status(n_status)
    );

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_pass(logic [3:0] c, logic [3:0] f);
        logic z, cf, n, v, b;
        z = f[3]; cf = f[2]; n = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (b ^ c[0]);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q_f.size() > 0) begin
            e = q_f.pop_front();
            chk("fwd out_valid", {2'b00, f_valid}, {2'b00, e.v});
            chk("fwd out_pass",  {2'b00, f_pass},  {2'b00, e.p});
            chk("fwd status",    f_status, e.st);
        end
        if (q_n.size() > 0) begin
            e = q_n.pop_front();
            chk("nofwd out_valid", {2'b00, n_valid}, {2'b00, e.v});
            chk("nofwd out_pass",  {2'b00, n_pass},  {2'b00, e.p});
            chk("nofwd status",    n_status, e.st);
        end
    end

    // Applies one bundle at posedge+1, queues what the next edge must produce.
    task automatic drive(input logic [1:0] v, input logic [7:0] c, input logic [1:0] s,
                         input logic [7:0] f, input logic stl, input logic fl,
                         input exp_t ef, input exp_t en);
        in_valid = v; in_cond = c; in_s = s; in_flags = f;
        stall = stl; flush = fl;
        @(posedge clk);
        q_f.push_back(ef);
        q_n.push_back(en);
        #1;
    endtask

    initial begin
        logic [3:0] sn;
        logic       r;
        int         budget;

        #1 rst = 1'b1;
        #1;
        chk("reset fwd status", f_status, 4'b0000);
        chk("reset fwd valid",  {2'b00, f_valid}, 4'b0000);
        chk("reset fwd pass",   {2'b00, f_pass},  4'b0000);
        chk("reset nofwd status", n_status, 4'b0000);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // lane0 AL writes Z; lane1 EQ sees it only with forwarding
        drive(2'b11, {EQ, AL}, 2'b01, 8'b0000_1000, 0, 0,
              {2'b11, 2'b11, 4'b1000}, {2'b11, 2'b01, 4'b1000});
        // clear flags, then a failing EQ with S=1 must not write
        drive(2'b01, {AL, AL}, 2'b01, 8'b0000_0000, 0, 0,
              {2'b01, 2'b01, 4'b0000}, {2'b01, 2'b01, 4'b0000});
        drive(2'b01, {EQ, EQ}, 2'b01, 8'b0000_0100, 0, 0,
              {2'b01, 2'b00, 4'b0000}, {2'b01, 2'b00, 4'b0000});
        // youngest writer wins
        drive(2'b11, {AL, AL}, 2'b11, 8'b0001_0010, 0, 0,
              {2'b11, 2'b11, 4'b0001}, {2'b11, 2'b11, 4'b0001});
        // invalid lane0 would write 1111 but is ignored
        drive(2'b10, {NE, AL}, 2'b01, 8'b0000_1111, 0, 0,
              {2'b10, 2'b10, 4'b0001}, {2'b10, 2'b10, 4'b0001});
        // lane1 fails with S=1: no write
        drive(2'b11, {EQ, AL}, 2'b10, 8'b1111_0000, 0, 0,
              {2'b11, 2'b01, 4'b0001}, {2'b11, 2'b01, 4'b0001});
        drive(2'b11, {AL, AL}, 2'b01, 8'b0000_0100, 0, 0,
              {2'b11, 2'b11, 4'b0100}, {2'b11, 2'b11, 4'b0100});
        // stall two cycles with a bundle that would otherwise change everything
        drive(2'b01, {AL, EQ}, 2'b11, 8'b1111_1010, 1, 0,
              {2'b11, 2'b11, 4'b0100}, {2'b11, 2'b11, 4'b0100});
        drive(2'b01, {AL, EQ}, 2'b11, 8'b1111_1010, 1, 0,
              {2'b11, 2'b11, 4'b0100}, {2'b11, 2'b11, 4'b0100});
        // flush beats stall; then flush alone
        drive(2'b11, {AL, AL}, 2'b11, 8'b1111_1010, 1, 1,
              {2'b00, 2'b00, 4'b0100}, {2'b00, 2'b00, 4'b0100});
        drive(2'b11, {AL, AL}, 2'b11, 8'b1111_1010, 0, 1,
              {2'b00, 2'b00, 4'b0100}, {2'b00, 2'b00, 4'b0100});
        drive(2'b11, {AL, AL}, 2'b11, 8'b1111_1010, 0, 0,
              {2'b11, 2'b11, 4'b1111}, {2'b11, 2'b11, 4'b1111});

        // all condition codes against all flag values via lane0 -> lane1 forwarding
        sn = 4'b1111;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                r = ref_pass(4'(c), 4'(f));
                drive(2'b11, {4'(c), AL}, 2'b01, {4'b0000, 4'(f)}, 0, 0,
                      {2'b11, r, 1'b1, 4'(f)},
                      {2'b11, ref_pass(4'(c), sn), 1'b1, 4'(f)});
                sn = 4'(f);
            end
        end

        // async reset mid-bundle; first edge after release processes the present inputs
        @(negedge clk); #1;
        in_valid = 2'b11; in_cond = {AL, AL}; in_s = 2'b01; in_flags = 8'b0000_0110;
        stall = 1'b0; flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midreset fwd status", f_status, 4'b0000);
        chk("midreset fwd valid",  {2'b00, f_valid}, 4'b0000);
        chk("midreset fwd pass",   {2'b00, f_pass},  4'b0000);
        chk("midreset nofwd status", n_status, 4'b0000);
        chk("midreset nofwd valid",  {2'b00, n_valid}, 4'b0000);
        #1 rst = 1'b0;
        @(posedge clk);
        q_f.push_back({2'b11, 2'b11, 4'b0110});
        q_n.push_back({2'b11, 2'b11, 4'b0110});
        #1;
        in_valid = 2'b00;

        budget = 20;
        while ((q_f.size() > 0 || q_n.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q_f.size() > 0 || q_n.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q_f.size(), q_n.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
